mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one sram-like bus master port (req/addr_ok/data_ok handshake) between the CPU's instruction-fetch port and its data port.
- CPU side is SRAM-style: single-cycle intent, with results held until the pipeline advances.
- Stalls the whole pipeline until every request enabled in the current pipeline cycle has completed on the bus.
- Sits between the core datapath and the bus bridge / cache.

Parameters:
- ADDR_W, 32, address width of both CPU ports and the bus.
- DATA_W, 32, data width; must equal 32, because the size encoding assumes 4 byte lanes.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-low.
- inst_en  in  1  fetch request this pipeline cycle.
- inst_addr  in  ADDR_W  fetch address (pcF).
- inst_rdata  out  DATA_W  fetched instruction (held).
- data_en  in  1  load/store request (mem_enM).
- data_wen  in  4  byte write enables (selectM for stores); 0 = load.
- data_addr  in  ADDR_W  data address (aluoutM).
- data_wdata  in  DATA_W  store data (lane-aligned).
- data_rdata  out  DATA_W  load data, full word (held).
- ext_stall  in  1  other pipeline stall sources (divider, hazard unit).
- stall_o  out  1  arbiter stall to the hazard unit.
- bus_req  out  1  bus request.
- bus_wr  out  1  1 = write.
- bus_size  out  2  0 = byte, 1 = half, 2 = word.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_addr_ok  in  1  address accepted.
- bus_data_ok  in  1  data returned / write done.
- bus_rdata  in  DATA_W  read data.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State IDLE; inst_done = data_done = 0.
  - inst_rdata = data_rdata = 0; bus_req = 0; bus_wr = 0; bus_size = 0; bus_addr = 0; bus_wdata = 0.
  - A reset mid-transaction abandons it; any late data_ok is ignored because the state is IDLE.
- stall_o = (inst_en & ~inst_done) | (data_en & ~data_done). It is combinational from the registered flags and the inputs.
- advance = ~stall_o & ~ext_stall. When advance=1 at a clk edge, both done flags clear. The rdata registers keep their values until the next capture.
- States: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT.
- Only one transaction is outstanding at any time.
- IDLE:
  - If data_en & ~data_done, go to D_REQ. Data has priority: the instruction in MEM is older.
  - Else if inst_en & ~inst_done, go to I_REQ.
  - Else stay in IDLE.
  - Exception: in the cycle where advance=1, stay in IDLE, so new-cycle requests are evaluated next cycle.
- D_REQ:
  - Drives bus_req=1 and bus_wr = |data_wen.
  - Load: bus_size = 2 and bus_addr = {data_addr[ADDR_W-1:2], 2'b00}.
  - Store: size and byte offset come from data_wen:
    - 0001 → size 0, offset 00
    - 0010 → size 0, offset 01
    - 0100 → size 0, offset 10
    - 1000 → size 0, offset 11
    - 0011 → size 1, offset 00
    - 1100 → size 1, offset 10
    - 1111 → size 2, offset 00
    - any other pattern → size 2, offset 00
  - bus_wdata = data_wdata.
  - Outputs are registered and stable while bus_req=1 and bus_addr_ok=0.
  - bus_addr_ok=1 → D_WAIT, and bus_req drops next cycle.
- D_WAIT:
  - On bus_data_ok: data_rdata ← bus_rdata (for loads only; stores leave it unchanged); data_done ← 1; return to IDLE.
- I_REQ / I_WAIT:
  - Same handshake as D_REQ / D_WAIT, with bus_wr=0, size 2, aligned inst_addr.
  - On bus_data_ok: inst_rdata ← bus_rdata; inst_done ← 1.
- Both requests in one cycle: data then instruction, back to back. stall_o stays 1 until both done flags are set. Minimum total latency is 2 bus transactions, plus 1 cycle in IDLE between them.
- bus_data_ok outside a WAIT state is ignored.
- bus_addr_ok and bus_data_ok for the same transaction never coincide; data_ok comes at least 1 cycle after addr_ok.
- ext_stall=1 with both flags done: stall_o=0, the flags and rdata hold, and no new request is issued.
- Once addr_ok is received a transaction always completes. There is no abort path; the core suppresses faulting accesses via data_en.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE=0, D_REQ=1, D_WAIT=2, I_REQ=3, I_WAIT=4, 3 bits);
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD constants.
- One sub-module, wen_size_decode: combinational data_wen → {bus_size, addr offset}. It is reused by the future AXI bridge.

Test Plan:
- Fetch only: inst_en=1, addr 0xBFC00004; addr_ok after 2 cycles, data_ok 3 cycles later with 0x24080001 → stall_o high 6 cycles, inst_rdata=0x24080001, stall_o=0 next cycle.
- Simultaneous: load at 0x80000012 (wen 0) plus fetch → bus_addr 0x80000010 (size 2) first, then the fetch address; stall_o drops only after the second data_ok.
- Byte store: wen 0100, addr 0x80000000, wdata 0x00AB0000 → bus_wr=1, size 0, bus_addr 0x80000002; data_rdata unchanged.
- ext_stall held for 3 cycles after completion → no new bus_req and rdata stable; flags clear on the first advance, then the next fetch issues.
- addr_ok held low for 5 cycles → bus_req, bus_addr and bus_wdata constant throughout; stray data_ok while in D_REQ is ignored.
- rst=0 asserted in D_WAIT, then a late data_ok → state IDLE, all outputs 0, done flags 0, rdata 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter: FSM states and bus size codes.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_REQ  = 3'd1,
        D_WAIT = 3'd2,
        I_REQ  = 3'd3,
        I_WAIT = 3'd4
    } arbStateT;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/wen_size_decode.sv
// Maps a 4-lane store byte-enable pattern to a bus transfer size and byte offset.
module wen_size_decode
    import mem_arb_pkg::*;
(
    input  logic [3:0] wen,
    output logic [1:0] size,
    output logic [1:0] offset
);

    always_comb begin
        size   = SIZE_WORD;
        offset = 2'b00;
        case (wen)
            4'b0001: begin size = SIZE_BYTE; offset = 2'b00; end
            4'b0010: begin size = SIZE_BYTE; offset = 2'b01; end
            4'b0100: begin size = SIZE_BYTE; offset = 2'b10; end
            4'b1000: begin size = SIZE_BYTE; offset = 2'b11; end
            4'b0011: begin size = SIZE_HALF; offset = 2'b00; end
            4'b1100: begin size = SIZE_HALF; offset = 2'b10; end
            // Full-word and malformed enable patterns both go out as an aligned word.
            default: begin size = SIZE_WORD; offset = 2'b00; end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one sram-like bus master between the fetch and data ports, stalling the
// pipeline until every request enabled this pipeline cycle has completed.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_en,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_en,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    input  logic              ext_stall,
    output logic              stall_o,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    if (DATA_W != 32) begin : gDataWidthCheck
        $error("mem_port_arbiter: DATA_W must be 32 (4 byte lanes)");
    end

    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    arbStateT state;
    logic     instDone;
    logic     dataDone;
    logic     advance;
    logic     isStore;
    logic [1:0] decSize;
    logic [1:0] decOffset;

    wen_size_decode uWenDecode (
        .wen    (data_wen),
        .size   (decSize),
        .offset (decOffset)
    );

    assign stall_o = (inst_en & ~instDone) | (data_en & ~dataDone);
    assign advance = ~stall_o & ~ext_stall;
    assign isStore = |data_wen;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            instDone   <= 1'b0;
            dataDone   <= 1'b0;
            inst_rdata <= '0;
            data_rdata <= '0;
            bus_req    <= 1'b0;
            bus_wr     <= 1'b0;
            bus_size   <= SIZE_BYTE;
            bus_addr   <= '0;
            bus_wdata  <= '0;
        end else begin
            if (advance) begin
                instDone <= 1'b0;
                dataDone <= 1'b0;
            end
            case (state)
                // New-cycle requests are only looked at one cycle after the advance edge.
                IDLE: if (!advance) begin
                    if (data_en && !dataDone) begin
                        state     <= D_REQ;
                        bus_req   <= 1'b1;
                        bus_wr    <= isStore;
                        bus_size  <= isStore ? decSize : SIZE_WORD;
                        bus_addr  <= (data_addr & WORD_MASK) |
                                     {{(ADDR_W-2){1'b0}}, (isStore ? decOffset : 2'b00)};
                        bus_wdata <= data_wdata;
                    end else if (inst_en && !instDone) begin
                        state    <= I_REQ;
                        bus_req  <= 1'b1;
                        bus_wr   <= 1'b0;
                        bus_size <= SIZE_WORD;
                        bus_addr <= inst_addr & WORD_MASK;
                    end
                end
                D_REQ, I_REQ: if (bus_addr_ok) begin
                    state   <= (state == D_REQ) ? D_WAIT : I_WAIT;
                    bus_req <= 1'b0;
                end
                D_WAIT: if (bus_data_ok) begin
                    // bus_wr still holds the direction of the outstanding data access.
                    if (!bus_wr) data_rdata <= bus_rdata;
                    dataDone <= 1'b1;
                    state    <= IDLE;
                end
                I_WAIT: if (bus_data_ok) begin
                    inst_rdata <= bus_rdata;
                    instDone   <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
